// File: rtl/rabbit_xor_stream.sv
// Rabbit keystream XOR stage: captures 128-bit keystream blocks, XORs them word by
// word onto a 32-bit input stream and buffers the results in a small output FIFO.
module rabbit_xor_stream #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [127:0] ks_in,
  input  logic         ks_ready,
  output logic         ks_en,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  word_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WAIT_KS, HAVE_KS} state_t;

  state_t          state_q, state_d;
  logic [127:0]    kbuf_q, kbuf_d;
  logic [1:0]      widx_q, widx_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     wcnt_q, wcnt_d;
  logic [32:0]     mem [FIFO_DEPTH];

  logic            full, empty, capture, push, pop;
  logic [31:0]     ks_word;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign ks_word = kbuf_q[{widx_q, 5'd0} +: 32];

  // ks_en is combinational from ks_ready, so it is explicitly held low during reset.
  assign capture = rst_n && !clear && (state_q == WAIT_KS) && ks_ready;
  assign ks_en   = capture;
  assign s_ready = !clear && (state_q == HAVE_KS) && !full;
  assign push    = s_valid && s_ready;
  assign pop     = !clear && !empty && m_ready;

  assign m_valid  = !empty;
  assign m_data   = empty ? 32'd0 : mem[rd_q][31:0];
  assign m_last   = empty ? 1'b0  : mem[rd_q][32];
  assign word_cnt = wcnt_q;

  always_comb begin
    state_d = state_q;
    kbuf_d  = kbuf_q;
    widx_d  = widx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    if (clear) begin
      state_d = WAIT_KS;
      widx_d  = 2'd0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      wcnt_d  = 32'd0;
    end else begin
      if (capture) begin
        kbuf_d  = ks_in;
        widx_d  = 2'd0;
        state_d = HAVE_KS;
      end
      if (push) begin
        widx_d = widx_q + 2'd1;
        wr_d   = wr_q + AW'(1);
        wcnt_d = wcnt_q + 32'd1;
        if (widx_q == 2'd3) state_d = WAIT_KS;
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_KS;
      kbuf_q  <= '0;
      widx_q  <= 2'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      kbuf_q  <= kbuf_d;
      widx_q  <= widx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {s_last, s_data ^ ks_word};
  end

endmodule
